// File: rtl/pulse_seq_pkg.sv
// Shared types and helpers for the pulse sequence transmitter.
//   state_t        : sequencer FSM states (IDLE, FETCH, RUN)
//   syms_per_word  : symbols packed into one 32-bit memory word
//   sym_extract    : pull symbol <idx> out of a memory word
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic int syms_per_word(input int sym_bits);
    return 32 / sym_bits;
  endfunction

  localparam int DEF_SYM_BITS  = 2;
  localparam int SYMS_PER_WORD = syms_per_word(DEF_SYM_BITS);

  // Symbol idx occupies word bits [idx*sym_bits +: sym_bits].
  function automatic logic [7:0] sym_extract(input logic [31:0] word,
                                             input int          idx,
                                             input int          sym_bits);
    logic [31:0] mask;
    logic [31:0] sh;
    mask = (32'd1 << sym_bits) - 32'd1;
    sh   = word >> (idx * sym_bits);
    return 8'(sh & mask);
  endfunction

endpackage

// File: rtl/pulse_seq_timer.sv
// Loadable symbol-length countdown.
//   load   : (re)start with length (dur+1) << pre
//   run    : count enable
//   dur    : duration table entry of the symbol being loaded
//   pre    : prescaler exponent
//   expire : high during the last cycle of the loaded length; a load in
//            that same cycle starts the next symbol with no gap
module pulse_seq_timer #(
  parameter int DUR_W = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [DUR_W-1:0] dur,
  input  logic [PRE_W-1:0] pre,
  output logic             expire
);

  // Wide enough for (2^DUR_W) << (2^PRE_W - 1).
  localparam int CNT_W = DUR_W + (1 << PRE_W);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;

  assign len    = (CNT_W'(dur) + CNT_W'(1)) << pre;
  assign expire = run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= len - CNT_W'(1);
    else if (run && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/pulse_seq_transmitter.sv
// Symbol-sequence pulse transmitter core.
// Plays SYM_BITS-wide symbols from a word memory; each symbol picks a
// duration entry, its MSB is the output level. Supports looping passes,
// stop, live status and a sticky done interrupt.
//   start/stop            : one-cycle strobes (stop wins)
//   cfg_first/loop/end_pc : sequence bounds, cfg_repeat passes (0 = forever)
//   cfg_prescaler         : length = (dur+1) << cfg_prescaler
//   cfg_durations         : packed table, entry s at [s*DUR_W +: DUR_W]
//   cfg_idle_level/invert : output level when idle / final inversion
//   cfg_carrier_en/half   : carrier gating of high symbols
//   mem_we/addr/wdata     : symbol memory write port
//   tx_out, carrier_out, busy, pc_out, passes_left, irq, irq_clr : status
// Optional build macro PULSE_SEQ_CARRIER_EN adds the carrier generator;
// without it carrier_out is 0 and high symbols are unmodulated.
module pulse_seq_transmitter
  import pulse_seq_pkg::*;
#(
  parameter int SYM_BITS  = 2,
  parameter int MEM_WORDS = 8,
  parameter int DUR_W     = 8,
  parameter int PRE_W     = 4,
  parameter int REP_W     = 8,
  parameter int CAR_W     = 16,
  localparam int PC_W     = $clog2(MEM_WORDS * 32 / SYM_BITS),
  localparam int MA_W     = $clog2(MEM_WORDS),
  localparam int NSYM     = 1 << SYM_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PC_W-1:0]       cfg_first_pc,
  input  logic [PC_W-1:0]       cfg_loop_pc,
  input  logic [PC_W-1:0]       cfg_end_pc,
  input  logic [REP_W-1:0]      cfg_repeat,
  input  logic [PRE_W-1:0]      cfg_prescaler,
  input  logic [NSYM*DUR_W-1:0] cfg_durations,
  input  logic                  cfg_idle_level,
  input  logic                  cfg_invert,
  input  logic                  cfg_carrier_en,
  input  logic [CAR_W-1:0]      cfg_carrier_half,
  input  logic                  mem_we,
  input  logic [MA_W-1:0]       mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  tx_out,
  output logic                  carrier_out,
  output logic                  busy,
  output logic [PC_W-1:0]       pc_out,
  output logic [REP_W-1:0]      passes_left,
  output logic                  irq,
  input  logic                  irq_clr
);

  localparam int IDX_W = PC_W - MA_W;

  logic [31:0] mem [MEM_WORDS];

  state_t            state, state_n;
  logic [PC_W-1:0]   fpc, fpc_n;        // next symbol to fetch
  logic [PC_W-1:0]   cur_pc, cur_pc_n;  // symbol currently on air
  logic [REP_W-1:0]  passes, passes_n;
  logic              last, last_n;      // symbol on air ends the sequence
  logic              level, level_n;
  logic              irq_r, irq_n;
  logic              tx_r, tx_n;
  logic              load, expire, car_mod;

  logic [31:0]          fword;
  logic [SYM_BITS-1:0]  fsym;
  logic [DUR_W-1:0]     fdur;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Fetch path: memory is read at load time, so a write lands on the
  // next fetch of that word.
  assign fword = mem[fpc[PC_W-1 -: MA_W]];
  assign fsym  = SYM_BITS'(sym_extract(fword, int'(fpc[IDX_W-1:0]), SYM_BITS));
  assign fdur  = cfg_durations[int'(fsym)*DUR_W +: DUR_W];

  pulse_seq_timer #(.DUR_W(DUR_W), .PRE_W(PRE_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .run    (state == ST_RUN),
    .dur    (fdur),
    .pre    (cfg_prescaler),
    .expire (expire)
  );

  always_comb begin
    state_n  = state;
    fpc_n    = fpc;
    cur_pc_n = cur_pc;
    passes_n = passes;
    last_n   = last;
    level_n  = level;
    irq_n    = irq_r & ~irq_clr;
    load     = 1'b0;

    if (stop) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state_n  = ST_FETCH;
          fpc_n    = cfg_first_pc;
          cur_pc_n = cfg_first_pc;
          passes_n = cfg_repeat;
          last_n   = 1'b0;
        end
        ST_FETCH: begin
          load    = 1'b1;
          state_n = ST_RUN;
        end
        ST_RUN: if (expire) begin
          if (last) begin
            state_n = ST_IDLE;
            irq_n   = 1'b1;       // completion beats a same-cycle irq_clr
          end else begin
            load = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // Loading a symbol also decides where the following fetch comes from.
    if (load) begin
      cur_pc_n = fpc;
      level_n  = fsym[SYM_BITS-1];
      if (fpc == cfg_end_pc) begin
        fpc_n = cfg_loop_pc;
        if (passes == REP_W'(1))  last_n   = 1'b1;
        else if (passes != '0)    passes_n = passes - REP_W'(1);
      end else begin
        fpc_n = fpc + PC_W'(1);
      end
    end
  end

`ifdef PULSE_SEQ_CARRIER_EN
  logic [CAR_W-1:0] car_cnt, car_cnt_n;
  logic             car_r, car_n;

  // Counter restarts from zero whenever the sequencer leaves IDLE.
  always_comb begin
    car_cnt_n = '0;
    car_n     = 1'b0;
    if (state != ST_IDLE && state_n != ST_IDLE) begin
      if (car_cnt == cfg_carrier_half) begin
        car_n = ~car_r;
      end else begin
        car_cnt_n = car_cnt + CAR_W'(1);
        car_n     = car_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      car_cnt <= '0;
      car_r   <= 1'b0;
    end else begin
      car_cnt <= car_cnt_n;
      car_r   <= car_n;
    end
  end

  assign car_mod     = cfg_carrier_en ? car_n : 1'b1;
  assign carrier_out = car_r;
`else
  logic unused_carrier;
  assign unused_carrier = ^{cfg_carrier_en, cfg_carrier_half};
  assign car_mod        = 1'b1;
  assign carrier_out    = 1'b0;
`endif

  // Output register built from next-cycle values so tx_out lines up with busy.
  assign tx_n = ((state_n == ST_RUN) ? (level_n & car_mod) : cfg_idle_level) ^ cfg_invert;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      fpc    <= '0;
      cur_pc <= '0;
      passes <= '0;
      last   <= 1'b0;
      level  <= 1'b0;
      irq_r  <= 1'b0;
      tx_r   <= 1'b0;
    end else begin
      state  <= state_n;
      fpc    <= fpc_n;
      cur_pc <= cur_pc_n;
      passes <= passes_n;
      last   <= last_n;
      level  <= level_n;
      irq_r  <= irq_n;
      tx_r   <= tx_n;
    end
  end

  assign tx_out      = tx_r;
  assign busy        = (state != ST_IDLE);
  assign pc_out      = cur_pc;
  assign passes_left = passes;
  assign irq         = irq_r;

endmodule

// File: tb/tb_pulse_seq_transmitter.sv
// Self-checking bench for pulse_seq_transmitter (default parameters).
// A timeline model expands the configured sequence into per-cycle expected
// outputs; a negedge compare process checks them, and directed literal
// checks pin key cycles of each scenario.
module tb_pulse_seq_transmitter;

`ifdef PULSE_SEQ_CARRIER_EN
  localparam bit HAS_CAR = 1'b1;
`else
  localparam bit HAS_CAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, stop, irq_clr, mem_we;
  logic [6:0]  cfg_first_pc, cfg_loop_pc, cfg_end_pc;
  logic [7:0]  cfg_repeat;
  logic [3:0]  cfg_prescaler;
  logic [31:0] cfg_durations;
  logic        cfg_idle_level, cfg_invert, cfg_carrier_en;
  logic [15:0] cfg_carrier_half;
  logic [2:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        tx_out, carrier_out, busy, irq;
  logic [6:0]  pc_out;
  logic [7:0]  passes_left;

  always #5 clk = ~clk;

  pulse_seq_transmitter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_first_pc(cfg_first_pc), .cfg_loop_pc(cfg_loop_pc), .cfg_end_pc(cfg_end_pc),
    .cfg_repeat(cfg_repeat), .cfg_prescaler(cfg_prescaler), .cfg_durations(cfg_durations),
    .cfg_idle_level(cfg_idle_level), .cfg_invert(cfg_invert),
    .cfg_carrier_en(cfg_carrier_en), .cfg_carrier_half(cfg_carrier_half),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .tx_out(tx_out), .carrier_out(carrier_out), .busy(busy), .pc_out(pc_out),
    .passes_left(passes_left), .irq(irq), .irq_clr(irq_clr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit       tx;
    bit       car;
    bit       busy;
    bit [6:0] pc;
    bit [7:0] pl;
    bit       pc_vld;
    bit       irq;
  } exp_t;

  exp_t     exp_q[$];
  exp_t     ce;
  bit [31:0] mmem [8];
  bit [6:0] m_pc;
  bit [7:0] m_pl;
  bit       m_known;
  bit       m_irq;

  function automatic bit car_at(input int c, input int half);
    if (!HAS_CAR) return 1'b0;
    return bit'(((c - 1) / (half + 1)) % 2);
  endfunction

  function automatic int dur_of(input int s);
    return int'((cfg_durations >> (s * 8)) & 32'hFF);
  endfunction

  task automatic push(input bit tx, car, bsy, input bit [6:0] pc, input bit [7:0] pl,
                      input bit vld, irqv);
    exp_t e;
    e.tx = tx; e.car = car; e.busy = bsy; e.pc = pc; e.pl = pl;
    e.pc_vld = vld; e.irq = irqv;
    exp_q.push_back(e);
  endtask

  // Expected outputs for cycles 0..ncyc where start is sampled in cycle 0.
  task automatic model_run(input bit [6:0] first, loop_pc, end_pc, input int rep, pre,
                           input bit inv, idle, car_en, input int half, stop_at,
                           output int ncyc);
    int c, j, len, pv;
    bit [6:0] p;
    int s;
    bit is_end, done, stopped, car, lvl;
    push(idle ^ inv, 1'b0, 1'b0, m_pc, m_pl, m_known, m_irq);
    push(idle ^ inv, car_at(1, half), 1'b1, first, 8'(rep), 1'b1, m_irq);
    p = first; j = 1; c = 2; done = 0; stopped = 0;
    while (!done && !stopped && c < 4000) begin
      s      = int'((mmem[p / 16] >> ((p % 16) * 2)) & 32'h3);
      len    = (dur_of(s) + 1) << pre;
      is_end = (p == end_pc);
      if (rep == 0)    pv = 0;
      else if (is_end) pv = (j == rep) ? 1 : rep - j;
      else             pv = rep - j + 1;
      for (int k = 0; k < len; k++) begin
        if (stop_at >= 0 && c > stop_at) begin stopped = 1; break; end
        car = car_at(c, half);
        lvl = (s >= 2) && (car_en && HAS_CAR ? car : 1'b1);
        push(lvl ^ inv, car, 1'b1, p, 8'(pv), 1'b1, m_irq);
        c++;
      end
      if (!stopped) begin
        if (is_end) begin
          if (rep != 0 && j == rep) done = 1;
          else begin j++; p = loop_pc; end
        end else begin
          p = p + 7'd1;
        end
      end
    end
    if (stopped) begin
      push(idle ^ inv, 1'b0, 1'b0, 7'd0, 8'd0, 1'b0, m_irq);
      m_known = 0;
    end else begin
      push(idle ^ inv, 1'b0, 1'b0, p, 8'((rep == 0) ? 0 : 1), 1'b1, 1'b1);
      m_pc = p; m_pl = 8'((rep == 0) ? 0 : 1); m_known = 1; m_irq = 1;
    end
    ncyc = c;
  endtask

  // Single compare process.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("cyc_tx", int'(tx_out), int'(ce.tx));
      chk("cyc_carrier", int'(carrier_out), int'(ce.car));
      chk("cyc_busy", int'(busy), int'(ce.busy));
      chk("cyc_irq", int'(irq), int'(ce.irq));
      if (ce.pc_vld) begin
        chk("cyc_pc", int'(pc_out), int'(ce.pc));
        chk("cyc_passes", int'(passes_left), int'(ce.pl));
      end
    end
  end

  // ---------------- driver ----------------
  bit tx_h [512];
  bit busy_h [512];
  int pl_h [512];
  int pc_h [512];

  task automatic rec(input int c);
    if (c < 512) begin
      tx_h[c] = tx_out; busy_h[c] = busy; pl_h[c] = int'(passes_left); pc_h[c] = int'(pc_out);
    end
  endtask

  task automatic run_seq(input bit [6:0] first, loop_pc, end_pc, input int rep, pre,
                         input bit inv, idle, car_en, input int half,
                         input int stop_at, restart_at, clr_at, output int ncyc);
    @(posedge clk); #1;
    cfg_first_pc = first; cfg_loop_pc = loop_pc; cfg_end_pc = end_pc;
    cfg_repeat = 8'(rep); cfg_prescaler = 4'(pre); cfg_invert = inv;
    cfg_idle_level = idle; cfg_carrier_en = car_en; cfg_carrier_half = 16'(half);
    @(posedge clk); #1;
    model_run(first, loop_pc, end_pc, rep, pre, inv, idle, car_en, half, stop_at, ncyc);
    rec(0);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      rec(c);
      start   = (c == restart_at);
      stop    = (c == stop_at);
      irq_clr = (c == clr_at);
    end
    start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n, highs;
    rst_n = 0; start = 0; stop = 0; irq_clr = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    cfg_first_pc = 0; cfg_loop_pc = 0; cfg_end_pc = 0; cfg_repeat = 0; cfg_prescaler = 0;
    cfg_durations = {8'd4, 8'd3, 8'd2, 8'd1};
    cfg_idle_level = 1; cfg_invert = 0; cfg_carrier_en = 0; cfg_carrier_half = 16'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(tx_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_passes", int'(passes_left), 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_carrier", int'(carrier_out), 0);
    rst_n = 1; cfg_idle_level = 0;
    m_pc = 0; m_pl = 0; m_known = 1; m_irq = 0;
    for (int a = 0; a < 8; a++) begin
      mem_we = 1; mem_addr = 3'(a); mem_wdata = (a == 0) ? 32'h0000_00E4 : 32'h0;
      mmem[a] = mem_wdata;
      @(posedge clk); #1;
    end
    mem_we = 0;

    // basic four-symbol pass
    run_seq(0, 0, 3, 1, 0, 0, 0, 0, 1, -1, -1, -1, n);
    chk("t1_len", n, 16);
    chk("t1_busy1", int'(busy_h[1]), 1);
    chk("t1_tx6", int'(tx_h[6]), 0);
    chk("t1_tx7", int'(tx_h[7]), 1);
    chk("t1_tx15", int'(tx_h[15]), 1);
    chk("t1_busy15", int'(busy_h[15]), 1);
    chk("t1_busy16", int'(busy_h[16]), 0);
    chk("t1_tx16", int'(tx_h[16]), 0);
    chk("t1_irq", int'(irq), 1);

    // single symbol 3, dur 3, prescaler 2; irq_clr on the completion cycle
    cfg_durations = {8'd3, 8'd3, 8'd2, 8'd1};
    run_seq(3, 3, 3, 1, 2, 0, 0, 0, 1, -1, -1, 17, n);
    chk("t2_len", n, 18);
    highs = 0;
    for (int c = 0; c <= n; c++) highs += int'(tx_h[c]);
    chk("t2_highs", highs, 16);
    chk("t2_tx2", int'(tx_h[2]), 1);
    chk("t2_tx18", int'(tx_h[18]), 0);
    chk("t2_irq_kept", int'(irq), 1);
    cfg_durations = {8'd4, 8'd3, 8'd2, 8'd1};

    // looping passes with a start while busy
    run_seq(0, 2, 3, 3, 0, 0, 0, 0, 1, -1, 5, -1, n);
    chk("t3_len", n, 34);
    chk("t3_pl1", pl_h[1], 3);
    chk("t3_pl10", pl_h[10], 3);
    chk("t3_pl11", pl_h[11], 2);
    chk("t3_pl20", pl_h[20], 1);
    chk("t3_pc6", pc_h[6], 1);
    chk("t3_pc16", pc_h[16], 2);
    chk("t3_pc33", pc_h[33], 3);
    chk("t3_busy34", int'(busy_h[34]), 0);

    // irq_clr
    @(posedge clk); #1 irq_clr = 1;
    @(posedge clk); #1 irq_clr = 0;
    chk("irq_clr", int'(irq), 0);
    m_irq = 0;

    // infinite repeat, stop at cycle 100
    run_seq(0, 0, 3, 0, 0, 0, 0, 0, 1, 100, -1, -1, n);
    chk("t4_len", n, 101);
    chk("t4_busy100", int'(busy_h[100]), 1);
    chk("t4_busy101", int'(busy_h[101]), 0);
    chk("t4_tx101", int'(tx_h[101]), 0);
    chk("t4_pl50", pl_h[50], 0);
    chk("t4_irq", int'(irq), 0);

    // start and stop together
    @(posedge clk); #1 start = 1; stop = 1;
    @(posedge clk); #1 start = 0; stop = 0;
    chk("ss_busy_a", int'(busy), 0);
    @(posedge clk); #1;
    chk("ss_busy_b", int'(busy), 0);
    chk("ss_irq", int'(irq), 0);

    // inversion and carrier on high symbols
    run_seq(2, 2, 3, 1, 0, 1, 0, 1, 1, -1, -1, -1, n);
    chk("t5_len", n, 11);
    chk("t5_idle_inv", int'(tx_h[0]), 1);
    chk("t5_tx3", int'(tx_h[3]), 0);
`ifdef PULSE_SEQ_CARRIER_EN
    chk("t5_tx2", int'(tx_h[2]), 1);
    chk("t5_tx5", int'(tx_h[5]), 1);
    chk("t5_tx7", int'(tx_h[7]), 0);
`else
    chk("t5_tx5", int'(tx_h[5]), 0);
`endif
    chk("t5_tx11", int'(tx_h[11]), 1);

    // reset in the middle of a run (irq is set, tx idle level is 1)
    @(posedge clk); #1 start = 1;
    for (int c = 1; c <= 5; c++) begin @(posedge clk); #1 start = 0; end
    chk("mr_busy_before", int'(busy), 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mr_tx", int'(tx_out), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_pc", int'(pc_out), 0);
    chk("mr_passes", int'(passes_left), 0);
    chk("mr_irq", int'(irq), 0);
    chk("mr_carrier", int'(carrier_out), 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("mr_idle_after", int'(tx_out), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_seq_transmitter.md
Name: pulse_seq_transmitter

Overview:
Parametrised symbol-sequence pulse transmitter core for the TinyQV peripheral wrapper.
- Plays SYM_BITS-wide symbols from an internal word memory.
- Each symbol selects a duration-table entry; the symbol's MSB gives the output level.
- Adds finite repeat counts, a stop command, live status and a sticky done interrupt.
- The bus-facing wrapper drives the cfg_* and mem_* ports and reads back the status outputs.

Parameters:
SYM_BITS, 2, bits per symbol; one of 1/2/4/8; duration table has 2^SYM_BITS entries
MEM_WORDS, 8, 32-bit words of symbol memory (power of two)
DUR_W, 8, duration entry width
PRE_W, 4, prescaler exponent width
REP_W, 8, repeat counter width
CAR_W, 16, carrier half-period counter width
Derived: PC_W = clog2(MEM_WORDS*32/SYM_BITS), MA_W = clog2(MEM_WORDS)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle start strobe
stop  in  1  one-cycle abort strobe
cfg_first_pc  in  PC_W  first symbol of pass 1
cfg_loop_pc  in  PC_W  first symbol of passes 2..N
cfg_end_pc  in  PC_W  last symbol of every pass
cfg_repeat  in  REP_W  total passes; 0 = infinite
cfg_prescaler  in  PRE_W  duration multiplier exponent
cfg_durations  in  (2^SYM_BITS)*DUR_W  packed table; entry s at [s*DUR_W +: DUR_W]
cfg_idle_level  in  1  level when not transmitting
cfg_invert  in  1  final output inversion
cfg_carrier_en  in  1  gate high symbols with carrier
cfg_carrier_half  in  CAR_W  carrier half-period minus 1
mem_we  in  1  symbol memory write enable
mem_addr  in  MA_W  memory word address
mem_wdata  in  32  memory write data
tx_out  out  1  modulated/inverted output (registered)
carrier_out  out  1  raw carrier
busy  out  1  sequence active
pc_out  out  PC_W  current symbol index
passes_left  out  REP_W  remaining passes
irq  out  1  sticky done interrupt
irq_clr  in  1  clears irq

Behaviour:
- Reset values: tx_out 0, carrier_out 0, busy 0, pc_out 0, passes_left 0, irq 0, FSM IDLE. Memory contents are not reset.
- Symbol fetch:
  - word = pc / (32/SYM_BITS).
  - symbol = word bits [(pc mod (32/SYM_BITS))*SYM_BITS +: SYM_BITS].
  - level = symbol MSB.
  - Length in cycles = (dur[symbol]+1) << cfg_prescaler.
- FSM states:
  - IDLE: on start (and no stop) -> FETCH; pc <= cfg_first_pc; passes_left <= cfg_repeat.
  - FETCH: one cycle; loads prefetch registers (level, length); advances pc -> RUN.
  - RUN: current symbol counts down. During the last cycle of each symbol, the prefetched symbol is loaded with no gap and the next symbol is prefetched.
  - End of final symbol of final pass -> IDLE.
- Latency: start sampled at cycle 0; busy=1 at cycle 1; first symbol on tx_out at cycle 2.
- Pass end (prefetch pc == cfg_end_pc):
  - If passes_left==1: last symbol, no further prefetch.
  - Otherwise, if passes_left!=0, decrement passes_left.
  - Next pc = cfg_loop_pc.
  - cfg_repeat=0: infinite; passes_left holds 0.
- pc increments modulo 2^PC_W.
- Completion: on the cycle the last symbol expires:
  - tx_out returns to idle, busy falls, irq sets.
  - pc_out holds the last pc.
- tx_out = (busy_valid ? (level & (cfg_carrier_en ? carrier : 1)) : cfg_idle_level) ^ cfg_invert, registered.
- Carrier: runs only while busy, reset to 0 at start; toggles every cfg_carrier_half+1 cycles.
- stop: in any state, next cycle returns to IDLE with tx_out idle, busy 0, and no irq.
- Start/stop interactions:
  - start+stop in the same cycle: stop wins.
  - start while busy: ignored.
- irq: irq_clr and completion in the same cycle -> irq stays 1.
- mem writes allowed anytime; a write takes effect at the next fetch of that word.
- cfg_durations/prescaler are sampled at each fetch. Other cfg fields are read live; changing them while busy is unsupported but must not hang the FSM.
- rst_n low mid-run: all outputs take reset values on the next edge.

Optional Feature:
PULSE_SEQ_CARRIER_EN
- Defined: carrier counter present; cfg_carrier_en and cfg_carrier_half are honoured.
- Undefined: no carrier logic; carrier_out tied 0; cfg_carrier_en and cfg_carrier_half ignored; high symbols are unmodulated.

Decomposition:
- Package pulse_seq_pkg:
  - FSM state enum (IDLE, FETCH, RUN).
  - Constant SYMS_PER_WORD = 32/SYM_BITS.
  - Function for symbol extraction.
- One sub-module, pulse_seq_timer: loadable countdown taking length = (dur+1)<<pre. Asserts expire on the last cycle; reloads back-to-back.

Test Plan:
- SYM_BITS=2, word0=0x000000E4, durations {1,2,3,4}, prescaler 0, first 0, end 3, repeat 1 -> start at cycle 0 gives:
  - tx_out low 2, low 3, high 4, high 5 cycles from cycle 2.
  - busy falls at cycle 16; irq=1.
- Single symbol 3, dur 3, prescaler 2 -> high for exactly 16 cycles.
- first 0, loop 2, end 3, repeat 3 -> symbol order 0,1,2,3,2,3,2,3; passes_left 3->2->1 then done with irq.
- repeat 0, stop at cycle 100 -> tx_out idle at 101, busy 0, irq 0. Also: start+stop in the same cycle -> stays IDLE.
- invert=1, idle 0 -> idle tx_out=1. With carrier_en and half=1 -> high symbols toggle every 2 cycles (inverted).
- start while busy ignored (pc unchanged); irq_clr clears irq; rst_n low mid-run -> all outputs 0 next cycle.
